// File: rtl/pixel_window_capture_if.sv
// ---------------------------------------------------------------------------
// pixel_window_capture_if
//   Bundles the camera-side pixel stream, the capture controls and the
//   memory write port of pixel_window_capture.
//
//   Camera side:   pixel_data, pixel_valid, frame_start
//   Control:       arm, threshold, busy, done, short_frame
//   Memory port:   wr_data, wr_addr, wr_en
//
//   Modports:
//     slave  - the capture block (consumes pixels, produces writes)
//     master - the environment (drives pixels and controls)
// ---------------------------------------------------------------------------
interface pixel_window_capture_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [7:0]        pixel_data;
  logic              pixel_valid;
  logic              frame_start;
  logic              arm;
  logic [7:0]        threshold;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              done;
  logic              busy;
  logic              short_frame;

  modport slave (
    input  pixel_data, pixel_valid, frame_start, arm, threshold,
    output wr_data, wr_addr, wr_en, done, busy, short_frame
  );

  modport master (
    output pixel_data, pixel_valid, frame_start, arm, threshold,
    input  wr_data, wr_addr, wr_en, done, busy, short_frame
  );
endinterface

// File: rtl/pixel_window_capture.sv
// ---------------------------------------------------------------------------
// pixel_window_capture
//   Captures one full IMG_W x IMG_H window of a camera frame into a memory,
//   converting each 8-bit gray pixel into a signed fixed-point sample
//   (1.0 = 1 << FRAC_W). Capture is armed by 'arm', starts on the next
//   frame_start and ends after N = IMG_W*IMG_H valid pixels with a
//   one-cycle 'done' pulse. An early frame_start restarts the capture and
//   pulses 'short_frame'.
//
//   Ports:
//     clk    - clock, rising edge
//     reset  - asynchronous, active-high reset
//     bus    - pixel_window_capture_if.slave (pixel stream, controls,
//              memory write port)
//
//   Build option:
//     PIXEL_GRAY_OUT_EN defined   -> wr_data is the inverted gray level
//                                    placed at the top of the fraction;
//                                    threshold is ignored.
//     PIXEL_GRAY_OUT_EN undefined -> binary ink mask: pixel <= threshold
//                                    gives 1.0, otherwise 0.
// ---------------------------------------------------------------------------
module pixel_window_capture #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24
) (
  input logic                   clk,
  input logic                   reset,
  pixel_window_capture_if.slave bus
);

  localparam int                N        = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [1:0] {IDLE, ARMED, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] count, count_nxt;
  logic [ADDR_W-1:0] pix_idx;
  logic              accept;
  logic [DATA_W-1:0] sample;

  // Pixel-to-sample conversion.
`ifdef PIXEL_GRAY_OUT_EN
  logic [7:0] inv_gray;
  assign inv_gray = ~bus.pixel_data;
  // Inverted gray lands in the top 8 fraction bits, integer part zero.
  assign sample   = DATA_W'(inv_gray) << (FRAC_W - 8);
`else
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;
  // Dark pixels (at or below threshold) are ink.
  assign sample = (bus.pixel_data <= bus.threshold) ? ONE : '0;
`endif

  assign bus.busy = (state == ARMED) || (state == LOAD);

  // Next-state and pixel acceptance.
  // NOTE: every output of this block is given a default first so no path
  // leaves a variable unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pix_idx   = count;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (!bus.arm) begin
          state_nxt = IDLE;
        end else if (bus.frame_start) begin
          state_nxt = LOAD;
          count_nxt = '0;
        end
      end
      LOAD: begin
        // A frame_start restarts the window; a pixel in the same cycle
        // is pixel 0 of the new frame.
        if (bus.frame_start) pix_idx = '0;
        count_nxt = pix_idx;
        if (bus.pixel_valid) begin
          accept = 1'b1;
          if (pix_idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            count_nxt = pix_idx + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // State, counter and the registered write/status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.done        <= 1'b0;
      bus.short_frame <= 1'b0;
    end else begin
      state           <= state_nxt;
      count           <= count_nxt;
      bus.wr_en       <= accept;
      if (accept) begin
        bus.wr_addr <= pix_idx;
        bus.wr_data <= sample;
      end
      // DONE coincides with the last write; done follows one cycle later.
      bus.done        <= (state == DONE);
      bus.short_frame <= (state == LOAD) && bus.frame_start;
    end
  end

endmodule

// File: tb/tb_pixel_window_capture.sv
// ---------------------------------------------------------------------------
// tb_pixel_window_capture
//   Directed bench for pixel_window_capture with default parameters
//   (32x32 window, 10-bit address, 32-bit Q8.24 samples). Inputs change
//   1 time unit after the rising edge; outputs are checked at that point,
//   so each check sees the registered result of the pixel just applied.
// ---------------------------------------------------------------------------
module tb_pixel_window_capture;

  localparam int NPIX = 1024;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  pixel_window_capture_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  pixel_window_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of pixel-side inputs, then step past the next edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic fs);
    bus.pixel_valid = v;
    bus.pixel_data  = d;
    bus.frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  // Pixel pattern 0: alternating 0x10 / 0xF0; pattern 1: low byte of index.
  int pattern;
  function automatic logic [7:0] pix(input int idx);
    if (pattern == 0) return (idx % 2 == 0) ? 8'h10 : 8'hF0;
    return 8'(idx);
  endfunction

  // Expected sample with threshold 0x48.
  function automatic logic [31:0] exp_data(input logic [7:0] p);
`ifdef PIXEL_GRAY_OUT_EN
    return {8'h00, ~p, 16'h0000};
`else
    return (p <= 8'h48) ? 32'h0100_0000 : 32'h0000_0000;
`endif
  endfunction

  // Arm, enter LOAD on frame_start, then drop arm (LOAD must not abort).
  task automatic start_frame();
    bus.arm = 1'b1;
    drive(1'b1, 8'h00, 1'b0);      // pixel while ARMED, before frame_start
    check("armed_busy", bus.busy, 1'b1);
    check("armed_no_wr", bus.wr_en, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    check("load_busy", bus.busy, 1'b1);
    check("load_entry_no_wr", bus.wr_en, 1'b0);
    bus.arm = 1'b0;
  endtask

  task automatic feed(input int idx, input int gap);
    drive(1'b1, pix(idx), 1'b0);
    check($sformatf("wr_en[%0d]", idx), bus.wr_en, 1'b1);
    check($sformatf("wr_addr[%0d]", idx), bus.wr_addr, 64'(idx));
    check($sformatf("wr_data[%0d]", idx), bus.wr_data, exp_data(pix(idx)));
    for (int g = 0; g < gap; g++) begin
      drive(1'b0, 8'hAA, 1'b0);
      check($sformatf("gap_no_wr[%0d]", idx), bus.wr_en, 1'b0);
    end
  endtask

  // Checks after the last pixel of a frame has been applied (gap = 0).
  task automatic finish_frame();
    check("last_busy_low", bus.busy, 1'b0);
    check("last_no_done_yet", bus.done, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("done_pulse", bus.done, 1'b1);
    check("done_no_wr", bus.wr_en, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("done_cleared", bus.done, 1'b0);
    check("idle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    vec_cnt         = 0;
    err_cnt         = 0;
    pattern         = 0;
    reset           = 1'b1;
    bus.arm         = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_data  = 8'h00;
    bus.frame_start = 1'b0;
    bus.threshold   = 8'h48;

    // Reset state.
    #3;
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 64'd0);
    check("rst_wr_data", bus.wr_data, 64'd0);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_short", bus.short_frame, 1'b0);
    #9 reset = 1'b0;
    @(posedge clk);
    #1;

    // Not armed: frame_start and pixels are ignored.
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h10, 1'b0);
      check("unarmed_no_wr", bus.wr_en, 1'b0);
      check("unarmed_busy", bus.busy, 1'b0);
    end

    // arm dropped while ARMED returns to IDLE; later frame_start ignored.
    bus.arm = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    check("arm_busy", bus.busy, 1'b1);
    bus.arm = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check("disarm_busy", bus.busy, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h10, 1'b0);
    check("disarm_no_wr", bus.wr_en, 1'b0);

    // Full frame, alternating ink / background, no gaps.
    start_frame();
    for (int i = 0; i < NPIX; i++) feed(i, 0);
    finish_frame();

    // Full frame with 3-cycle gaps between pixels, ramp pattern.
    pattern = 1;
    start_frame();
    for (int i = 0; i < NPIX - 1; i++) feed(i, 3);
    feed(NPIX - 1, 0);
    finish_frame();

    // Early frame_start after 500 pixels; restart pixel arrives with it.
    pattern = 0;
    start_frame();
    for (int i = 0; i < 500; i++) feed(i, 0);
    drive(1'b1, pix(0), 1'b1);
    check("short_pulse", bus.short_frame, 1'b1);
    check("restart_wr_en", bus.wr_en, 1'b1);
    check("restart_addr", bus.wr_addr, 64'd0);
    check("restart_data", bus.wr_data, exp_data(pix(0)));
    for (int i = 1; i < NPIX; i++) begin
      feed(i, 0);
      if (i == 1) check("short_cleared", bus.short_frame, 1'b0);
    end
    finish_frame();

    // Conversion boundaries: black, white, at threshold, just above.
    start_frame();
    drive(1'b1, 8'h00, 1'b0);
`ifdef PIXEL_GRAY_OUT_EN
    check("conv_00", bus.wr_data, 32'h00FF_0000);
    drive(1'b1, 8'hFF, 1'b0);
    check("conv_ff", bus.wr_data, 32'h0000_0000);
    drive(1'b1, 8'h48, 1'b0);
    check("conv_48", bus.wr_data, 32'h00B7_0000);
    drive(1'b1, 8'h49, 1'b0);
    check("conv_49", bus.wr_data, 32'h00B6_0000);
`else
    check("conv_00", bus.wr_data, 32'h0100_0000);
    drive(1'b1, 8'hFF, 1'b0);
    check("conv_ff", bus.wr_data, 32'h0000_0000);
    drive(1'b1, 8'h48, 1'b0);
    check("conv_48", bus.wr_data, 32'h0100_0000);
    drive(1'b1, 8'h49, 1'b0);
    check("conv_49", bus.wr_data, 32'h0000_0000);
`endif
    check("conv_addr", bus.wr_addr, 64'd3);

    // Reset mid-frame after 200 more writes (restart on frame_start first).
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 200; i++) feed(i, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_wr_en", bus.wr_en, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_addr", bus.wr_addr, 64'd0);
    @(posedge clk);
    #4 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h10, 1'b0);
      check("postrst_done", bus.done, 1'b0);
      check("postrst_short", bus.short_frame, 1'b0);
      check("postrst_no_wr", bus.wr_en, 1'b0);
    end

    // Re-arm captures a complete frame from address 0.
    start_frame();
    for (int i = 0; i < NPIX; i++) feed(i, 0);
    finish_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pixel_window_capture.md
PIXEL_WINDOW_CAPTURE -- requirements
Module: pixel_window_capture

Interface
REQ-001 Parameter IMG_W, default 32, pixels per captured row.
REQ-002 Parameter IMG_H, default 32, captured rows; N = IMG_W*IMG_H.
REQ-003 Parameter ADDR_W, default 10, write-address width; SHALL satisfy 2**ADDR_W >= N.
REQ-004 Parameter DATA_W, default 32, signed fixed-point output word width.
REQ-005 Parameter FRAC_W, default 24, fraction bits; 1.0 = 1<<FRAC_W; SHALL satisfy 8 <= FRAC_W < DATA_W.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pixel_data  in  8  grayscale pixel, 0 = black.
REQ-009 pixel_valid  in  1  pixel_data lies inside the capture window this cycle.
REQ-010 frame_start  in  1  one-cycle pulse marking the start of a camera frame.
REQ-011 arm  in  1  level request to capture the next full frame window.
REQ-012 threshold  in  8  binarisation threshold.
REQ-013 wr_data  out  DATA_W  signed sample to the input memory.
REQ-014 wr_addr  out  ADDR_W  memory address, 0..N-1, row-major.
REQ-015 wr_en  out  1  write strobe.
REQ-016 done  out  1  one-cycle pulse: N samples written.
REQ-017 busy  out  1  high in ARMED or LOAD.
REQ-018 short_frame  out  1  one-cycle pulse: capture aborted by early frame_start.

Function
REQ-019 FSM states IDLE, ARMED, LOAD, DONE; encoding free.
REQ-020 IDLE -> ARMED when arm=1; otherwise stay.
REQ-021 ARMED -> LOAD on frame_start=1, with the pixel counter cleared to 0; pixels before frame_start are never written.
REQ-022 In LOAD, each cycle with pixel_valid=1 writes one sample at wr_addr=counter, then increments counter; cycles with pixel_valid=0 write nothing and hold counter.
REQ-023 A valid pixel at counter = N-1 is written and the FSM moves to DONE; counter never exceeds N-1.
REQ-024 DONE lasts exactly one cycle, asserts done, clears counter, and returns to IDLE regardless of arm.
REQ-025 frame_start in LOAD before N samples are written: pulse short_frame, clear counter, and stay in LOAD (restart on the new frame); a pixel_valid in the same cycle is the new frame's pixel 0.
REQ-026 Output write path is registered: wr_en/wr_addr/wr_data appear exactly one cycle after the accepted pixel; done appears in the cycle after the last write.
REQ-027 Binary mode: pixel_data <= threshold gives wr_data = 1<<FRAC_W (ink); otherwise wr_data = 0.
REQ-028 arm deasserted in ARMED returns to IDLE; arm deasserted in LOAD does not abort.
REQ-029 busy = 1 exactly in ARMED and LOAD; wr_en never asserts outside the cycle following a LOAD-accepted pixel.

Reset
REQ-030 reset=1 asynchronously forces IDLE, counter=0, wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0, short_frame=0.
REQ-031 reset mid-LOAD discards the partial frame; no done or short_frame pulse is produced.

Configuration
REQ-032 Macro PIXEL_GRAY_OUT_EN compiled in: wr_data = inverted gray, {(DATA_W-FRAC_W) zeros, ~pixel_data, (FRAC_W-8) zeros}; threshold is ignored.
REQ-033 Macro PIXEL_GRAY_OUT_EN absent: binary mode per REQ-027; FSM, timing, and addressing identical in both builds.

Verification
REQ-034 Default params, threshold=0x48, arm=1, frame_start, 1024 valid pixels alternating 0x10/0xF0 -> 1024 writes, addr 0..1023, data 0x01000000/0x00000000 alternating, done one cycle after write 1023.
REQ-035 pixel_valid gaps of 3 cycles between pixels -> addresses still contiguous 0..1023, no writes in gap cycles.
REQ-036 frame_start after 500 valid pixels -> short_frame pulse, next write at addr 0, then 1024 writes and done.
REQ-037 reset asserted after 200 writes -> wr_en=0 immediately, busy=0, no done; re-arm captures a full frame from addr 0.
REQ-038 arm=0 -> frame_start and valid pixels produce no writes, busy=0.
REQ-039 PIXEL_GRAY_OUT_EN defined, pixel 0x00 -> wr_data=0x00FF0000; pixel 0xFF -> 0x00000000.
